// File: rtl/fetch_redirect_ctrl_if.sv
// Request/response bundle between the fetch sequencer and its neighbours.
// master: the request side (MEM exceptions, interrupt sources, RET/RTI pop,
//         jump unit, hazard unit, fetch decode). It drives the requests and
//         observes the PC-mux and IF/ID controls.
// slave : the fetch_redirect_ctrl sequencer.
// Requests : exception, interrupt, SET_INT, pop_pc, jmp_sgn, stall, is_itype
// Responses: pc_sel[2:0], pc_en, flush_IF_ID, INT, imm_phase, int_pending
interface fetch_redirect_ctrl_if;
    logic       exception;
    logic       interrupt;
    logic       SET_INT;
    logic       pop_pc;
    logic       jmp_sgn;
    logic       stall;
    logic       is_itype;
    logic [2:0] pc_sel;
    logic       pc_en;
    logic       flush_IF_ID;
    logic       INT;
    logic       imm_phase;
    logic       int_pending;

    modport master (
        output exception,
        output interrupt,
        output SET_INT,
        output pop_pc,
        output jmp_sgn,
        output stall,
        output is_itype,
        input  pc_sel,
        input  pc_en,
        input  flush_IF_ID,
        input  INT,
        input  imm_phase,
        input  int_pending
    );

    modport slave (
        input  exception,
        input  interrupt,
        input  SET_INT,
        input  pop_pc,
        input  jmp_sgn,
        input  stall,
        input  is_itype,
        output pc_sel,
        output pc_en,
        output flush_IF_ID,
        output INT,
        output imm_phase,
        output int_pending
    );
endinterface

// File: rtl/fetch_redirect_ctrl.sv
// Fetch-stage next-PC sequencer.
// Chooses the next-PC source each cycle (reset vector, exception vector,
// interrupt vector, popped PC, jump target or PC+1), keeps the opcode and
// immediate of a two-word I-type fetch together so an interrupt never lands
// between them, and produces the IF/ID flush and interrupt-bubble strobes.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-high reset, overrides every request
//   bus (slave)  requests: exception, interrupt, SET_INT, pop_pc, jmp_sgn,
//                          stall, is_itype
//                controls: pc_sel[2:0]  (comb) 0 PC+1, 1 vec 32, 2 vec 0,
//                                              3 popped PC, 4 jump target
//                          pc_en        (comb) PC write enable
//                          INT          (comb) interrupt bubble strobe
//                          flush_IF_ID  (reg)  zero the IF/ID instruction
//                          imm_phase    (reg)  current word is an immediate
//                          int_pending  (reg)  interrupt waiting to be taken
module fetch_redirect_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    fetch_redirect_ctrl_if.slave  bus
);

    localparam int unsigned SEL_W = 3;

    localparam logic [SEL_W-1:0] SEL_SEQ   = SEL_W'(0);
    localparam logic [SEL_W-1:0] SEL_VEC32 = SEL_W'(1);
    localparam logic [SEL_W-1:0] SEL_VEC0  = SEL_W'(2);
    localparam logic [SEL_W-1:0] SEL_POP   = SEL_W'(3);
    localparam logic [SEL_W-1:0] SEL_JMP   = SEL_W'(4);

    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        S_RSTV = 2'd0,
        S_RUN  = 2'd1,
        S_IMM  = 2'd2,
        S_INTE = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              flush_q;
    logic              flush_d;
    logic              imm_q;
    logic              imm_d;
    logic              pend_q;
    logic              pend_d;

    logic [SEL_W-1:0]  sel_c;
    logic              enable_c;
    logic              int_c;
    logic              redirect_c;
    logic              int_req_c;
    logic              cnt_nz_c;

    // Any interrupt source this cycle.
    assign int_req_c = bus.interrupt | bus.SET_INT;
    assign cnt_nz_c  = (cnt_q != '0);

    // State and control registers. Flush is forced on through reset so the
    // IF/ID stage is empty while the reset vector is being fetched.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RSTV;
            cnt_q   <= '0;
            flush_q <= 1'b1;
            imm_q   <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            flush_q <= flush_d;
            imm_q   <= imm_d;
            pend_q  <= pend_d;
        end
    end

    // Next-PC priority, next state and redirect detection.
    always_comb begin
        state_d    = state_q;
        imm_d      = imm_q;
        sel_c      = SEL_SEQ;
        enable_c   = 1'b0;
        int_c      = 1'b0;
        redirect_c = 1'b0;

        if (reset) begin
            // Registers are reset in the sequential block; only the
            // combinational controls need forcing here.
            sel_c    = SEL_VEC32;
            enable_c = 1'b1;
        end else if (bus.exception) begin
            // Exception beats stall and any pending interrupt entry.
            sel_c      = SEL_VEC32;
            enable_c   = 1'b1;
            redirect_c = 1'b1;
        end else if (bus.stall) begin
            // Everything holds; an interrupt already being entered keeps
            // its bubble strobe up until the stall drops.
            int_c = (state_q == S_INTE);
        end else begin
            enable_c = 1'b1;
            unique case (state_q)
                S_RSTV: begin
                    sel_c      = SEL_VEC32;
                    redirect_c = 1'b1;
                end
                S_INTE: begin
                    redirect_c = 1'b1;
                    if (bus.pop_pc) begin
                        sel_c = SEL_POP;
                    end else if (bus.jmp_sgn) begin
                        sel_c = SEL_JMP;
                    end else begin
                        sel_c = SEL_VEC0;
                        int_c = 1'b1;
                    end
                end
                S_RUN: begin
                    if (bus.pop_pc) begin
                        sel_c      = SEL_POP;
                        redirect_c = 1'b1;
                    end else if (bus.jmp_sgn) begin
                        sel_c      = SEL_JMP;
                        redirect_c = 1'b1;
                    end else if (bus.is_itype && !imm_q) begin
                        // Opcode of a two-word instruction: the immediate
                        // must be fetched before any interrupt is taken.
                        state_d = S_IMM;
                        imm_d   = 1'b1;
                    end else if (pend_q) begin
                        state_d = S_INTE;
                    end
                end
                S_IMM: begin
                    // is_itype is meaningless here: the word is data.
                    if (bus.pop_pc) begin
                        sel_c      = SEL_POP;
                        redirect_c = 1'b1;
                    end else if (bus.jmp_sgn) begin
                        sel_c      = SEL_JMP;
                        redirect_c = 1'b1;
                    end else begin
                        // Instruction boundary reached after the immediate.
                        state_d = pend_q ? S_INTE : S_RUN;
                        imm_d   = 1'b0;
                    end
                end
            endcase
        end

        if (redirect_c) begin
            state_d = S_RUN;
            imm_d   = 1'b0;
        end
    end

    // Flush down-counter: reload on redirect, count only on enabled cycles
    // so a stall stretches the flush window.
    always_comb begin
        cnt_d = cnt_q;
        if (redirect_c) begin
            cnt_d = FLUSH_LOAD;
        end else if (enable_c && cnt_nz_c) begin
            cnt_d = cnt_q - CNT_ONE;
        end
        flush_d = (cnt_d != '0);
    end

    // Pending interrupt: a new request in the strobe cycle keeps it armed.
    always_comb begin
        pend_d = int_req_c | (pend_q & ~int_c);
    end

    assign bus.pc_sel      = sel_c;
    assign bus.pc_en       = enable_c;
    assign bus.INT         = int_c;
    assign bus.flush_IF_ID = flush_q;
    assign bus.imm_phase   = imm_q;
    assign bus.int_pending = pend_q;

endmodule
